// File: rtl/mul_sequencer.sv
// mul_sequencer
// -------------
// Multi-cycle shift-add multiplier controller for the CPU's `mul` instruction.
// The controller latches both operands when START is seen in IDLE. It then
// retires one multiplier bit per clock in RUN. Finally it spends one cycle in
// WB, where the product is written back through WRITEENABLE/WRITEADDR/RESULT.
// STALL holds the PC while the operation is in flight.
//
// Optional feature (compile-time macro MUL_EARLY_EXIT_EN):
//   When defined, RUN ends as soon as no set multiplier bits remain. RUN
//   still lasts at least one cycle. When undefined, RUN always lasts WIDTH
//   cycles.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous, active-low reset
//   START        in   current instruction is `mul` (level, held for the instr)
//   DATA1        in   multiplicand, WIDTH bits
//   DATA2        in   multiplier, WIDTH bits
//   DEST         in   destination register address, 3 bits
//   STALL        out  hold PC (combinational)
//   BUSY         out  registered, high in RUN and WB
//   WRITEENABLE  out  reg_file write strobe, high in WB only
//   WRITEADDR    out  latched DEST
//   RESULT       out  low WIDTH bits of the product
//   RESULT_HI    out  high WIDTH bits of the product

module mul_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       DEST,
  output logic             STALL,
  output logic             BUSY,
  output logic             WRITEENABLE,
  output logic [2:0]       WRITEADDR,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           waddr_q, waddr_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 busy_q, busy_d;
  logic                 last_iter;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath. RESULT/RESULT_HI load from the final
  // accumulator value (acc_d) on the edge that enters WB. That way the
  // product is already stable while WRITEENABLE is high.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    last_iter   = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          mcand_d  = {{WIDTH{1'b0}}, DATA1};
          mplier_d = DATA2;
          acc_d    = '0;
          cnt_d    = '0;
          waddr_d  = DEST;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef MUL_EARLY_EXIT_EN
        // Once the remaining multiplier bits are all zero, the later
        // iterations would add nothing, so the product is already final.
        last_iter = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
        last_iter = (cnt_q == LAST_CNT);
`endif
        if (last_iter) begin
          state_d     = WB;
          result_d    = acc_d[WIDTH-1:0];
          result_hi_d = acc_d[2*WIDTH-1:WIDTH];
        end
      end

      WB: begin
        // START still high here belongs to the instruction being retired.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // STALL is gated by RESET. While RESET is low, a START held high in IDLE
  // cannot keep the PC frozen.
  always_comb begin
    STALL       = RESET && (((state_q == IDLE) && START) || (state_q == RUN));
    WRITEENABLE = (state_q == WB);
  end

  assign BUSY      = busy_q;
  assign WRITEADDR = waddr_q;
  assign RESULT    = result_q;
  assign RESULT_HI = result_hi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
// ----------------
// Table-driven bench for mul_sequencer with WIDTH=8. Each vector runs a
// full `mul` instruction, and the bench checks the following:
//   - STALL cycle count
//   - the cycle in which the write occurs
//   - the number of write pulses
//   - product halves, write address and BUSY
// Hand-written sequences cover these cases:
//   - back-to-back instructions
//   - asynchronous reset in the middle of RUN

module tb_mul_sequencer;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] DEST;
  logic       STALL;
  logic       BUSY;
  logic       WRITEENABLE;
  logic [2:0] WRITEADDR;
  logic [7:0] RESULT;
  logic [7:0] RESULT_HI;

  int errors = 0;
  int checks = 0;

  mul_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .DATA1      (DATA1),
    .DATA2      (DATA2),
    .DEST       (DEST),
    .STALL      (STALL),
    .BUSY       (BUSY),
    .WRITEENABLE(WRITEENABLE),
    .WRITEADDR  (WRITEADDR),
    .RESULT     (RESULT),
    .RESULT_HI  (RESULT_HI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] dest;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  vec_t vecs[7];

  // Observations made by applyStimulus.
  int         obsWeCycle;
  int         obsStallCnt;
  int         obsWeCnt;
  logic [7:0] obsLo;
  logic [7:0] obsHi;
  logic [2:0] obsAddr;
  logic       obsBusy;

  // Expected RUN length. With early exit, this is the bit length of the
  // multiplier (minimum 1). Otherwise it is always 8.
  function automatic int expRun(input logic [7:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) n = i + 1;
`ifdef MUL_EARLY_EXIT_EN
    return (n == 0) ? 1 : n;
`else
    return (n > 8) ? n : 8;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one instruction just after a rising edge, with the DUT in IDLE.
  // Cycle 1 is the cycle in which START first appears. START is dropped
  // after the write edge, and one extra cycle checks for a second pulse.
  task automatic applyStimulus(input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] dest);
    obsWeCycle  = 0;
    obsStallCnt = 0;
    obsWeCnt    = 0;
    obsLo       = 'x;
    obsHi       = 'x;
    obsAddr     = 'x;
    obsBusy     = 1'b0;
    DATA1 = d1;
    DATA2 = d2;
    DEST  = dest;
    START = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (STALL) obsStallCnt++;
      if (WRITEENABLE) begin
        obsWeCnt++;
        obsWeCycle = c;
        obsLo      = RESULT;
        obsHi      = RESULT_HI;
        obsAddr    = WRITEADDR;
        obsBusy    = BUSY;
      end
      // Operands change after E0 to confirm they were latched.
      @(posedge CLK);
      #1;
      DATA1 = ~d1;
      DATA2 = ~d2;
      DEST  = ~dest;
      if (obsWeCnt != 0) break;
    end
    START = 1'b0;
    @(negedge CLK);
    if (WRITEENABLE) obsWeCnt++;
    if (STALL) obsStallCnt++;
    @(posedge CLK);
    #1;
  endtask

  int weCycles[2];
  logic [7:0] weRes[2];
  logic [2:0] weAddr[2];
  int weCnt;
  logic stallAfterWe;
  int resetWe;

  initial begin
    // Each entry holds d1, d2, dest and the expected low/high product bytes.
    vecs[0] = '{d1: 8'h05, d2: 8'h06, dest: 3'd3, lo: 8'h1E, hi: 8'h00};
    vecs[1] = '{d1: 8'hFF, d2: 8'hFF, dest: 3'd5, lo: 8'h01, hi: 8'hFE};
    vecs[2] = '{d1: 8'h10, d2: 8'h10, dest: 3'd7, lo: 8'h00, hi: 8'h01};
    vecs[3] = '{d1: 8'h09, d2: 8'h01, dest: 3'd2, lo: 8'h09, hi: 8'h00};
    vecs[4] = '{d1: 8'h09, d2: 8'h00, dest: 3'd4, lo: 8'h00, hi: 8'h00};
    vecs[5] = '{d1: 8'h80, d2: 8'h80, dest: 3'd6, lo: 8'h00, hi: 8'h40};
    vecs[6] = '{d1: 8'hA5, d2: 8'h3C, dest: 3'd1, lo: 8'hAC, hi: 8'h26};

    RESET = 1'b0;
    START = 1'b0;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    DEST  = 3'd0;
    #23;
    checkOutput("reset STALL", STALL, 0);
    checkOutput("reset BUSY", BUSY, 0);
    checkOutput("reset WRITEENABLE", WRITEENABLE, 0);
    checkOutput("reset WRITEADDR", WRITEADDR, 0);
    checkOutput("reset RESULT", RESULT, 0);
    checkOutput("reset RESULT_HI", RESULT_HI, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].d1, vecs[v].d2, vecs[v].dest);
      checkOutput($sformatf("v%0d stall cycles", v), obsStallCnt, expRun(vecs[v].d2) + 1);
      checkOutput($sformatf("v%0d write cycle", v), obsWeCycle, expRun(vecs[v].d2) + 2);
      checkOutput($sformatf("v%0d write pulses", v), obsWeCnt, 1);
      checkOutput($sformatf("v%0d RESULT", v), obsLo, vecs[v].lo);
      checkOutput($sformatf("v%0d RESULT_HI", v), obsHi, vecs[v].hi);
      checkOutput($sformatf("v%0d WRITEADDR", v), obsAddr, vecs[v].dest);
      checkOutput($sformatf("v%0d BUSY in WB", v), obsBusy, 1);
      checkOutput($sformatf("v%0d BUSY after", v), BUSY, 0);
    end

    // Back-to-back: 3*4 -> R1, then 7*2 -> R2. START stays high throughout.
    weCnt = 0;
    stallAfterWe = 1'b0;
    weCycles[0] = 0;
    weCycles[1] = 0;
    weRes[0] = 'x;
    weRes[1] = 'x;
    weAddr[0] = 'x;
    weAddr[1] = 'x;
    DATA1 = 8'd3;
    DATA2 = 8'd4;
    DEST  = 3'd1;
    START = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (weCnt == 1 && c == weCycles[0] + 1) stallAfterWe = STALL;
      if (WRITEENABLE) begin
        weCycles[weCnt] = c;
        weRes[weCnt]    = RESULT;
        weAddr[weCnt]   = WRITEADDR;
        weCnt++;
      end
      @(posedge CLK);
      #1;
      if (weCnt == 1 && c == weCycles[0]) begin
        DATA1 = 8'd7;
        DATA2 = 8'd2;
        DEST  = 3'd2;
      end
      if (weCnt == 2) break;
    end
    START = 1'b0;
    checkOutput("b2b pulse count", weCnt, 2);
    checkOutput("b2b first write cycle", weCycles[0], expRun(8'd4) + 2);
    checkOutput("b2b write spacing", weCycles[1] - weCycles[0], expRun(8'd2) + 2);
    checkOutput("b2b no bubble STALL", stallAfterWe, 1);
    checkOutput("b2b RESULT 1", weRes[0], 8'h0C);
    checkOutput("b2b RESULT 2", weRes[1], 8'h0E);
    checkOutput("b2b WRITEADDR 1", weAddr[0], 3'd1);
    checkOutput("b2b WRITEADDR 2", weAddr[1], 3'd2);
    @(posedge CLK);
    #1;

    // Asynchronous reset four cycles into RUN, between clock edges.
    DATA1 = 8'hFF;
    DATA2 = 8'hFF;
    DEST  = 3'd5;
    START = 1'b1;
    @(posedge CLK);
    repeat (4) @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    checkOutput("midrun reset STALL", STALL, 0);
    checkOutput("midrun reset BUSY", BUSY, 0);
    checkOutput("midrun reset WRITEENABLE", WRITEENABLE, 0);
    checkOutput("midrun reset RESULT", RESULT, 0);
    checkOutput("midrun reset RESULT_HI", RESULT_HI, 0);
    checkOutput("midrun reset WRITEADDR", WRITEADDR, 0);
    resetWe = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (WRITEENABLE) resetWe++;
    end
    START = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (WRITEENABLE) resetWe++;
    end
    checkOutput("midrun reset no write", resetWe, 0);
    @(posedge CLK);
    #1;

    applyStimulus(8'h05, 8'h06, 3'd3);
    checkOutput("post-reset write cycle", obsWeCycle, expRun(8'h06) + 2);
    checkOutput("post-reset write pulses", obsWeCnt, 1);
    checkOutput("post-reset RESULT", obsLo, 8'h1E);
    checkOutput("post-reset RESULT_HI", obsHi, 8'h00);
    checkOutput("post-reset WRITEADDR", obsAddr, 3'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
